// File: rtl/mdio_receptor.sv
// MDIO receptor (PHY side).
// Parses MDIO write and read frames one bit per clk. Writes produce a
// one-cycle register-file write strobe. Reads produce a one-cycle read strobe
// and then serialise the returned data back onto MDIO_IN.
//
// Handshake: a bit is transferred on a posedge only when its drive enable
// (MDIO_OE from the initiator, MDIO_IN_OE from this block) is high. No
// back-pressure exists, so the receptor must accept every bit offered.
// When the initiator drives during our own read turnaround or data phase,
// that is contention: the read is aborted.
module mdio_receptor #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        MEM_WR,
  output logic        MEM_RD,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_WDATA   = 3'd2,
    S_RD_TA   = 3'd3,
    S_RD_DATA = 3'd4,
    S_DISCARD = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_sh, w_sh_nxt;
  logic        r_mdio_in, w_mdio_in_nxt;
  logic        r_mdio_in_oe, w_mdio_in_oe_nxt;
  logic [4:0]  r_addr, w_addr_nxt;
  logic [15:0] r_wr_data, w_wr_data_nxt;
  logic        r_mem_wr, w_mem_wr_nxt;
  logic        r_mem_rd, w_mem_rd_nxt;
  logic        r_frame_err, w_frame_err_nxt;

  // Shift register with the current bit appended. The header is at most
  // 14 bits, so ST/OP/PHYAD/REGAD stay in fixed positions of this word
  // while the header is being captured.
  logic [15:0] w_sh_in;
  logic        w_hdr_bad;
  logic        w_phy_miss;
  logic        w_op_rd;
  logic        w_ta_bad;

  assign w_sh_in = {r_sh[14:0], MDIO_OUT};

  // Checks valid only on the bit that completes the respective field.
  assign w_hdr_bad  = (w_sh_in[3:2] != 2'b01) ||
                      !((w_sh_in[1:0] == 2'b01) || (w_sh_in[1:0] == 2'b10));
  assign w_phy_miss = (w_sh_in[4:0] != PHY_ADDR);
  assign w_op_rd    = (w_sh_in[11:10] == 2'b10);
  assign w_ta_bad   = (w_sh_in[1:0] != 2'b10);

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 5'd0;
      r_sh         <= 16'd0;
      r_mdio_in    <= 1'b0;
      r_mdio_in_oe <= 1'b0;
      r_addr       <= 5'd0;
      r_wr_data    <= 16'd0;
      r_mem_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sh         <= w_sh_nxt;
      r_mdio_in    <= w_mdio_in_nxt;
      r_mdio_in_oe <= w_mdio_in_oe_nxt;
      r_addr       <= w_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // Next-state decision from the current state, bit counter and line.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (MDIO_OE) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (!MDIO_OE)                               w_state_nxt = S_IDLE;
        else if ((r_cnt == 5'd3) && w_hdr_bad)      w_state_nxt = S_DISCARD;
        else if ((r_cnt == 5'd8) && w_phy_miss)     w_state_nxt = S_DISCARD;
        else if (r_cnt == 5'd13)                    w_state_nxt = w_op_rd ? S_RD_TA : S_WDATA;
      end
      S_WDATA: begin
        if (!MDIO_OE)                               w_state_nxt = S_IDLE;
        else if ((r_cnt == 5'd1) && w_ta_bad)       w_state_nxt = S_DISCARD;
        else if (r_cnt == 5'd17)                    w_state_nxt = S_IDLE;
      end
      S_RD_TA: begin
        if (MDIO_OE)                                w_state_nxt = S_DISCARD;
        else if (r_cnt == 5'd1)                     w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (MDIO_OE)                                w_state_nxt = S_DISCARD;
        else if (r_cnt == 5'd15)                    w_state_nxt = S_IDLE;
      end
      S_DISCARD: begin
        if (!MDIO_OE) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the counter, shift register and registered outputs.
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_sh_nxt         = r_sh;
    w_mdio_in_nxt    = r_mdio_in;
    w_mdio_in_oe_nxt = r_mdio_in_oe;
    w_addr_nxt       = r_addr;
    w_wr_data_nxt    = r_wr_data;
    w_mem_wr_nxt     = 1'b0;
    w_mem_rd_nxt     = 1'b0;
    w_frame_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mdio_in_nxt    = 1'b0;
        w_mdio_in_oe_nxt = 1'b0;
        if (MDIO_OE) begin
          w_sh_nxt  = {15'd0, MDIO_OUT};
          w_cnt_nxt = 5'd1;
        end
      end
      S_HEADER: begin
        if (!MDIO_OE) begin
          w_frame_err_nxt = 1'b1;
          w_cnt_nxt       = 5'd0;
        end else begin
          w_sh_nxt  = w_sh_in;
          w_cnt_nxt = r_cnt + 5'd1;
          if ((r_cnt == 5'd3) && w_hdr_bad) begin
            w_frame_err_nxt = 1'b1;
            w_cnt_nxt       = 5'd0;
          end else if ((r_cnt == 5'd8) && w_phy_miss) begin
            w_cnt_nxt = 5'd0;
          end else if (r_cnt == 5'd13) begin
            w_addr_nxt   = w_sh_in[4:0];
            w_mem_rd_nxt = w_op_rd;
            w_cnt_nxt    = 5'd0;
          end
        end
      end
      S_WDATA: begin
        if (!MDIO_OE) begin
          w_frame_err_nxt = 1'b1;
          w_cnt_nxt       = 5'd0;
        end else begin
          w_sh_nxt  = w_sh_in;
          w_cnt_nxt = r_cnt + 5'd1;
          if ((r_cnt == 5'd1) && w_ta_bad) begin
            w_frame_err_nxt = 1'b1;
            w_cnt_nxt       = 5'd0;
          end else if (r_cnt == 5'd17) begin
            w_wr_data_nxt = w_sh_in;
            w_mem_wr_nxt  = 1'b1;
            w_cnt_nxt     = 5'd0;
          end
        end
      end
      S_RD_TA: begin
        if (MDIO_OE) begin
          w_mdio_in_oe_nxt = 1'b0;
          w_mdio_in_nxt    = 1'b0;
          w_frame_err_nxt  = 1'b1;
          w_cnt_nxt        = 5'd0;
        end else if (r_cnt == 5'd0) begin
          // Drive the second turnaround bit as 0.
          w_mdio_in_oe_nxt = 1'b1;
          w_mdio_in_nxt    = 1'b0;
          w_cnt_nxt        = 5'd1;
        end else begin
          // Read data has arrived: latch it and present the MSB.
          w_sh_nxt      = RD_DATA;
          w_mdio_in_nxt = RD_DATA[15];
          w_cnt_nxt     = 5'd0;
        end
      end
      S_RD_DATA: begin
        if (MDIO_OE) begin
          w_mdio_in_oe_nxt = 1'b0;
          w_mdio_in_nxt    = 1'b0;
          w_frame_err_nxt  = 1'b1;
          w_cnt_nxt        = 5'd0;
        end else if (r_cnt == 5'd15) begin
          w_mdio_in_oe_nxt = 1'b0;
          w_mdio_in_nxt    = 1'b0;
          w_cnt_nxt        = 5'd0;
        end else begin
          w_mdio_in_nxt = r_sh[14];
          w_sh_nxt      = {r_sh[14:0], 1'b0};
          w_cnt_nxt     = r_cnt + 5'd1;
        end
      end
      S_DISCARD: begin
        w_cnt_nxt        = 5'd0;
        w_mdio_in_oe_nxt = 1'b0;
        w_mdio_in_nxt    = 1'b0;
      end
      default: begin
        w_cnt_nxt = 5'd0;
      end
    endcase
  end

  assign MDIO_IN    = r_mdio_in;
  assign MDIO_IN_OE = r_mdio_in_oe;
  assign ADDR       = r_addr;
  assign WR_DATA    = r_wr_data;
  assign MEM_WR     = r_mem_wr;
  assign MEM_RD     = r_mem_rd;
  assign FRAME_ERR  = r_frame_err;

endmodule

// File: tb/tb_mdio_receptor.sv
// Directed bench for mdio_receptor: write, read, foreign PHY, bad frames,
// contention, back-to-back frames and reset mid-frame.
module tb_mdio_receptor;

  logic        clk;
  logic        reset;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic        MDIO_IN_OE;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        MEM_WR;
  logic        MEM_RD;
  logic        FRAME_ERR;

  int checks = 0;
  int errors = 0;

  // Pulse / drive-cycle counters and protocol-rule violation count.
  int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_multi = 0;
  logic p_wr = 1'b0, p_rd = 1'b0, p_err = 1'b0;

  mdio_receptor #(.PHY_ADDR(5'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .MDIO_OE    (MDIO_OE),
    .MDIO_OUT   (MDIO_OUT),
    .RD_DATA    (RD_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDIO_IN_OE (MDIO_IN_OE),
    .ADDR       (ADDR),
    .WR_DATA    (WR_DATA),
    .MEM_WR     (MEM_WR),
    .MEM_RD     (MEM_RD),
    .FRAME_ERR  (FRAME_ERR)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts the cycle just ended (values seen before the edge updates them).
  always @(posedge clk) begin
    if (MEM_WR)     n_wr <= n_wr + 1;
    if (MEM_RD)     n_rd <= n_rd + 1;
    if (FRAME_ERR)  n_err <= n_err + 1;
    if (MDIO_IN_OE) n_oe <= n_oe + 1;
    if ((MEM_WR & MEM_RD) | (MEM_WR & FRAME_ERR) | (MEM_RD & FRAME_ERR) |
        (MEM_WR & p_wr) | (MEM_RD & p_rd) | (FRAME_ERR & p_err))
      n_multi <= n_multi + 1;
    p_wr  <= MEM_WR;
    p_rd  <= MEM_RD;
    p_err <= FRAME_ERR;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive n bits of v, MSB first, one per cycle with MDIO_OE high.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      MDIO_OE  = 1'b1;
      MDIO_OUT = v[i];
    end
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MDIO_OE  = 1'b0;
      MDIO_OUT = 1'b0;
    end
  endtask

  function automatic logic [31:0] wr_frame(input logic [4:0] phy, input logic [4:0] rga,
                                           input logic [1:0] ta, input logic [15:0] d);
    return {2'b01, 2'b01, phy, rga, ta, d};
  endfunction

  int b_wr, b_rd, b_err, b_oe;
  logic [31:0] f;
  logic [15:0] rd_exp;

  initial begin
    reset    = 1'b0;
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
    RD_DATA  = 16'h1234;
    rd_exp   = 16'h1234;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in", MDIO_IN, 0);
    chk("rst_in_oe", MDIO_IN_OE, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_wr_data", WR_DATA, 0);
    chk("rst_mem_wr", MEM_WR, 0);
    chk("rst_mem_rd", MEM_RD, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    reset = 1'b1;
    idle_cyc(2);

    // Valid write to register 3.
    b_wr = n_wr; b_err = n_err;
    send_bits(wr_frame(5'd0, 5'd3, 2'b10, 16'hA5C3), 32);
    @(negedge clk);
    chk("wr_mem_wr", MEM_WR, 1);
    chk("wr_addr", ADDR, 3);
    chk("wr_data", WR_DATA, 16'hA5C3);
    chk("wr_no_err", FRAME_ERR, 0);
    MDIO_OE = 1'b0;
    @(negedge clk);
    chk("wr_strobe_end", MEM_WR, 0);
    idle_cyc(2);
    chk("wr_count", n_wr - b_wr, 1);
    chk("wr_err_count", n_err - b_err, 0);

    // Read of register 7.
    b_rd = n_rd; b_oe = n_oe;
    send_bits({18'd0, 14'b01_10_00000_00111}, 14);
    @(negedge clk);
    chk("rd_mem_rd", MEM_RD, 1);
    chk("rd_addr", ADDR, 7);
    chk("rd_ta1_oe", MDIO_IN_OE, 0);
    MDIO_OE = 1'b0;
    @(negedge clk);
    chk("rd_ta2_oe", MDIO_IN_OE, 1);
    chk("rd_ta2_in", MDIO_IN, 0);
    chk("rd_strobe_end", MEM_RD, 0);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      chk($sformatf("rd_bit%0d", i), MDIO_IN, rd_exp[i]);
    end
    @(negedge clk);
    chk("rd_end_oe", MDIO_IN_OE, 0);
    chk("rd_end_in", MDIO_IN, 0);
    chk("rd_count", n_rd - b_rd, 1);
    chk("rd_oe_cycles", n_oe - b_oe, 17);

    // Bad start code.
    send_bits({28'd0, 4'b1101}, 4);
    @(negedge clk);
    chk("bad_st_err", FRAME_ERR, 1);
    MDIO_OUT = 1'b0;
    @(negedge clk);
    chk("bad_st_err_end", FRAME_ERR, 0);
    MDIO_OE = 1'b0;
    idle_cyc(1);

    // Write with bad turnaround.
    b_wr = n_wr; b_err = n_err;
    send_bits(wr_frame(5'd0, 5'd3, 2'b00, 16'hFFFF), 32);
    idle_cyc(3);
    chk("bad_ta_wr", n_wr - b_wr, 0);
    chk("bad_ta_err", n_err - b_err, 1);

    // Read of register 2 with initiator contention at E+5.
    send_bits({18'd0, 14'b01_10_00000_00010}, 14);
    idle_cyc(4);
    @(negedge clk);
    chk("cont_oe_before", MDIO_IN_OE, 1);
    MDIO_OE  = 1'b1;
    MDIO_OUT = 1'b1;
    @(negedge clk);
    chk("cont_oe_after", MDIO_IN_OE, 0);
    chk("cont_err", FRAME_ERR, 1);
    MDIO_OE = 1'b0;
    @(negedge clk);
    chk("cont_err_end", FRAME_ERR, 0);

    // Foreign PHY address.
    b_wr = n_wr; b_err = n_err; b_oe = n_oe;
    send_bits(wr_frame(5'd9, 5'd3, 2'b10, 16'hA5C3), 32);
    idle_cyc(2);
    chk("phy_wr", n_wr - b_wr, 0);
    chk("phy_err", n_err - b_err, 0);
    chk("phy_oe", n_oe - b_oe, 0);

    // Valid write then a back-to-back write starting in the strobe cycle.
    send_bits(wr_frame(5'd0, 5'd10, 2'b10, 16'h0F0F), 32);
    f = wr_frame(5'd0, 5'd17, 2'b10, 16'h5AA5);
    @(negedge clk);
    chk("b2b1_mem_wr", MEM_WR, 1);
    chk("b2b1_addr", ADDR, 10);
    chk("b2b1_data", WR_DATA, 16'h0F0F);
    MDIO_OE  = 1'b1;
    MDIO_OUT = f[31];
    send_bits(f, 31);
    @(negedge clk);
    chk("b2b2_mem_wr", MEM_WR, 1);
    chk("b2b2_addr", ADDR, 17);
    chk("b2b2_data", WR_DATA, 16'h5AA5);
    MDIO_OE = 1'b0;
    idle_cyc(1);

    // Reset during a write, then a full valid write.
    b_wr = n_wr;
    f = wr_frame(5'd0, 5'd4, 2'b10, 16'hDEAD);
    send_bits(f >> 12, 20);
    @(negedge clk);
    reset    = 1'b0;
    MDIO_OE  = 1'b1;
    MDIO_OUT = f[11];
    @(negedge clk);
    chk("mid_rst_addr", ADDR, 0);
    chk("mid_rst_data", WR_DATA, 0);
    chk("mid_rst_mem_wr", MEM_WR, 0);
    reset   = 1'b1;
    MDIO_OE = 1'b0;
    idle_cyc(1);
    send_bits(wr_frame(5'd0, 5'd6, 2'b10, 16'hBEEF), 32);
    @(negedge clk);
    chk("post_rst_mem_wr", MEM_WR, 1);
    chk("post_rst_addr", ADDR, 6);
    chk("post_rst_data", WR_DATA, 16'hBEEF);
    MDIO_OE = 1'b0;
    idle_cyc(2);
    chk("post_rst_count", n_wr - b_wr, 1);

    chk("strobe_rules", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
